// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and the queue entry record for the ALU result stage.
package alu_pkg;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 5;
  localparam int unsigned FLAG_W   = 4;

  // Flag bit positions within a {Z,N,C,V} nibble
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic [WIDTH-1:0]    result;
    logic [REG_BITS-1:0] rd;
    logic                wb_en;
    logic                set_flags;
    logic [FLAG_W-1:0]   flags;
  } entry_t;

endpackage

// File: rtl/alu_fifo2.sv
// Two-entry in-order queue of ALU result entries with synchronous flush.
module alu_fifo2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     dout,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;

  // Storage, pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: computes flags at entry, queues results, retires flags into the status register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = alu_pkg::WIDTH,
  parameter int unsigned REG_BITS = alu_pkg::REG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    Result,
  input  logic                carry_in,
  input  logic                ovf_in,
  input  logic                is_arith,
  input  logic                set_flags,
  input  logic [REG_BITS-1:0] rd,
  input  logic                wb_en,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [REG_BITS-1:0] out_rd,
  output logic                out_wb_en,
  output logic [3:0]          out_flags,
  output logic [3:0]          status_flags
);

  logic       ready_q;
  logic [1:0] count;
  logic       push;
  logic       pop;
  entry_t     din;
  entry_t     head;

  // Holds in_ready low through reset and releases it on the first edge afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  assign in_ready  = ready_q && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Builds the stored entry: flags evaluated now, writes to r0 suppressed
  always_comb begin
    din              = '0;
    din.result       = Result;
    din.rd           = rd;
    din.wb_en        = wb_en && (rd != '0);
    din.set_flags    = set_flags;
    din.flags[FLAG_Z] = (Result == '0);
    din.flags[FLAG_N] = Result[WIDTH-1];
    din.flags[FLAG_C] = carry_in & is_arith;
    din.flags[FLAG_V] = ovf_in & is_arith;
  end

  alu_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  assign out_result = head.result;
  assign out_rd     = head.rd;
  assign out_wb_en  = head.wb_en;
  assign out_flags  = head.flags;

  // Architectural flags update when a flag-setting entry retires, flush or not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     status_flags <= 4'b0000;
    else if (pop && head.set_flags) status_flags <= head.flags;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, queueing, flush and reset behaviour.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Result;
  logic        carry_in;
  logic        ovf_in;
  logic        is_arith;
  logic        set_flags;
  logic [4:0]  rd;
  logic        wb_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [3:0]  out_flags;
  logic [3:0]  status_flags;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Result       (Result),
    .carry_in     (carry_in),
    .ovf_in       (ovf_in),
    .is_arith     (is_arith),
    .set_flags    (set_flags),
    .rd           (rd),
    .wb_en        (wb_en),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_wb_en    (out_wb_en),
    .out_flags    (out_flags),
    .status_flags (status_flags)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o,
                       input logic a, input logic s, input logic [4:0] d, input logic w);
    in_valid = v; Result = r; carry_in = c; ovf_in = o;
    is_arith = a; set_flags = s; rd = d; wb_en = w;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step; step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_result !== 32'h0 || out_rd !== 5'd0 || out_wb_en !== 1'b0 || out_flags !== 4'b0000)
      begin fails++; $display("FAIL reset_out_fields got %h/%h/%b/%b want 0", out_result, out_rd, out_wb_en, out_flags); end
    checks++; if (status_flags !== 4'b0000) begin fails++; $display("FAIL reset_status got %b want 0000", status_flags); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL release_in_ready got %b want 0", in_ready); end
    step;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_zero_flags;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_out_valid got %b want 1", out_valid); end
    checks++; if (out_flags !== 4'b1000) begin fails++; $display("FAIL zero_out_flags got %b want 1000", out_flags); end
    checks++; if (out_rd !== 5'd3 || out_wb_en !== 1'b1) begin fails++; $display("FAIL zero_rd_wb got %0d/%b want 3/1", out_rd, out_wb_en); end
    checks++; if (status_flags !== 4'b0000) begin fails++; $display("FAIL zero_status_early got %b want 0000", status_flags); end
    step;
    checks++; if (status_flags !== 4'b1000) begin fails++; $display("FAIL zero_status got %b want 1000", status_flags); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL zero_drained got %b want 0", out_valid); end
  endtask

  task automatic test_full;
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    step;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_one_in_ready got %b want 1", in_ready); end
    drive(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    step;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    drive(1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b1;
    checks++; if (out_result !== 32'h8000_0001 || out_flags !== 4'b0100)
      begin fails++; $display("FAIL full_head0 got %h/%b want 80000001/0100", out_result, out_flags); end
    step;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h7FFF_FFFF || out_flags !== 4'b0000)
      begin fails++; $display("FAIL full_head1 got %b/%h/%b want 1/7fffffff/0000", out_valid, out_result, out_flags); end
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_blocked_absent got %b want 0", out_valid); end
    checks++; if (status_flags !== 4'b1000) begin fails++; $display("FAIL full_status_hold got %b want 1000", status_flags); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    step;
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234_5678)
      begin fails++; $display("FAIL b2b_head got %b/%h want 1/12345678", out_valid, out_result); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_count_one got in_ready %b want 1", in_ready); end
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_wb_and_flags;
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    step;
    checks++; if (out_wb_en !== 1'b0 || out_rd !== 5'd0) begin fails++; $display("FAIL r0_wb_en got %b/%0d want 0/0", out_wb_en, out_rd); end
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_flags !== 4'b1011 || out_wb_en !== 1'b1 || out_rd !== 5'd7)
      begin fails++; $display("FAIL arith_flags got %b/%b/%0d want 1011/1/7", out_flags, out_wb_en, out_rd); end
    step;
    checks++; if (status_flags !== 4'b1011) begin fails++; $display("FAIL arith_status got %b want 1011", status_flags); end
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_flags !== 4'b0100) begin fails++; $display("FAIL logic_cv_masked got %b want 0100", out_flags); end
    step;
    checks++; if (status_flags !== 4'b1011) begin fails++; $display("FAIL logic_status_hold got %b want 1011", status_flags); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1);
    step;
    drive(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b1);
    step;
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b1);
    step;
    flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL flush_full got valid %b ready %b want 0/1", out_valid, in_ready); end
    checks++; if (status_flags !== 4'b0100) begin fails++; $display("FAIL flush_pop_status got %b want 0100", status_flags); end
    drive(1'b1, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 1'b1);
    step;
    flush = 1'b1;
    drive(1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1);
    step;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    step;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_push_dropped got %b want 0", out_valid); end
    checks++; if (status_flags !== 4'b0100) begin fails++; $display("FAIL flush_status_hold got %b want 0100", status_flags); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1);
    step;
    drive(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 1'b1);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin fails++; $display("FAIL async_pre_full got valid %b ready %b want 1/0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || status_flags !== 4'b0000 || out_result !== 32'h0)
      begin fails++; $display("FAIL async_reset got %b/%b/%h want 0/0000/0", out_valid, status_flags, out_result); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL async_in_ready got %b want 0", in_ready); end
    step;
    rst_n = 1'b1;
    step;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fails++; $display("FAIL async_recover got ready %b valid %b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset;
    test_zero_flags;
    test_full;
    test_back_to_back;
    test_wb_and_flags;
    test_flush;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
